pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Generic, parametrised pipeline boundary register for the MIPS core. It replaces the hand-written per-stage latches (decode/exe, exe/mem, and so on).
- Carries an opaque payload bus plus an exception-type vector and a delay-slot flag between two stages.
- Uses a valid/ready handshake backed by a 2-entry skid buffer, so upstream ready is registered and never combinationally depends on downstream ready.
- Supports stall (hold) and flush. A flush that arrives during a stall is deferred until the stall releases, not lost.

Parameters:
- DATA_W, 192, payload width in bits (control fields plus operands, packed by the instantiating stage).
- EXC_W, 9, exception-type vector width.
- CNT_W, 16, width of the optional performance counters.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream offers an entry
- in_ready  out  1  buffer can accept; registered
- in_data  in  DATA_W  payload
- in_exc  in  EXC_W  exception-type vector
- in_ds  in  1  is-in-delay-slot flag
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts the head entry
- out_data  out  DATA_W  head payload
- out_exc  out  EXC_W  head exception vector
- out_ds  out  1  head delay-slot flag
- hold  in  1  stage stall; while high, no output transfer occurs
- flush  in  1  discard all held entries
- occupancy  out  2  number of valid entries (0, 1 or 2)
- stall_cnt  out  CNT_W  (macro only) cycles with out_valid=1 and no output transfer
- flush_cnt  out  CNT_W  (macro only) entries discarded by flushes

Behaviour:
- Storage: head register H (valid, data, exc, ds) drives the out_* ports directly. Skid register S is behind it.
- Handshake terms:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready & ~hold
- States, encoded by {S.valid, H.valid}:
  - EMPTY:
    - in_fire → ONE (load H).
  - ONE:
    - in_fire & out_fire → ONE (H ← input).
    - in_fire & ~out_fire → FULL (S ← input).
    - ~in_fire & out_fire → EMPTY.
  - FULL:
    - out_fire → ONE (H ← S, S cleared). in_ready is 0 in this state, so there is no in_fire.
- Ordering: strict FIFO order; no entry is ever duplicated or reordered.
- in_ready:
  - Registered; equals ~S.valid_next & ~flush_pend_next.
  - It is 1 in EMPTY and ONE, 0 in FULL.
  - The cycle after reset deasserts, in_ready is 1.
- Latency: one cycle from in_fire to out_valid when the buffer is empty. Throughput is one entry per cycle when out_ready=1 and hold=0.
- Flush with hold=0:
  - At the next edge H and S are cleared: valid=0, data/exc/ds zeroed.
  - in_fire in the same cycle is dropped.
  - out_fire in the same cycle still completes (the consumer took it).
- Flush with hold=1:
  - flush_pend is set and in_ready is forced to 0.
  - Contents are frozen while hold stays high.
  - On the first edge with hold=0, the clear is applied and flush_pend is cleared.
- Reset (async, any time, including mid-transfer or with a flush pending):
  - all valids, data, exc, ds, flush_pend and counters = 0
  - out_valid=0, out_data=0, out_exc=0, out_ds=0, occupancy=0, in_ready=0
- hold and out_ready: hold=1 with out_ready=1 gives no transfer, and out_* stay stable.
- Payload stability: out_data, out_exc and out_ds stay stable while out_valid=1 and no out_fire occurs.
- Masking: out_exc and out_ds are meaningful only while out_valid=1, but they are zero after a flush or reset.

Optional Feature:
- Macro: PIPE_STAGE_BUF_PERF_EN.
- With the macro defined, stall_cnt and flush_cnt exist:
  - stall_cnt increments each cycle with out_valid=1 and ~out_fire.
  - flush_cnt adds occupancy at each applied flush.
  - Both saturate at 2^CNT_W−1 and reset to 0.
- Without the macro, neither port nor any counter logic exists.

Test Plan:
- Streaming: in_valid=1 with in_data=1,2,3,4 on consecutive cycles, out_ready=1, hold=0. Required: out_data=1,2,3,4 one cycle later, occupancy stays 1, in_ready stays 1.
- Backpressure: push A=0xAA, then B=0xBB, with out_ready=0. Required: occupancy=2 and in_ready=0 at the cycle after B. Then raise out_ready=1: out_data=0xAA, then 0xBB, then out_valid=0, with in_ready=1 returning one cycle after the first drain.
- Flush when FULL, hold=0, with in_valid=1 and data 0xCC. Required: next cycle occupancy=0, out_valid=0, out_exc=0, and 0xCC is never output.
- Deferred flush: flush pulses for 1 cycle with hold=1 and occupancy=1. Required: while hold=1, out_data is unchanged and in_ready=0. Drop hold: one edge later out_valid=0, then in_ready=1.
- Async reset asserted mid-cycle while FULL with a flush pending. Required: all outputs 0 immediately, without waiting for a clock edge. After release, in_ready=1 at the first edge and occupancy=0.
- With PIPE_STAGE_BUF_PERF_EN defined: hold for 5 cycles with occupancy=1, then flush at occupancy=2. Required: stall_cnt=5 and flush_cnt=2. Also force stall_cnt to saturation and check it holds at 0xFFFF.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: 2-entry skid pipeline register (head H feeds out_*, skid S behind it), 1-cycle latency, registered in_ready.
// Flush under hold is deferred until hold drops; stall/flush counters exist only with `PIPE_STAGE_BUF_PERF_EN defined.
module pipe_stage_buf #(
  parameter int DATA_W = 192,
  parameter int EXC_W  = 9
`ifdef PIPE_STAGE_BUF_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              in_ds,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_ds,
  input  logic              hold,
  input  logic              flush,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_BUF_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] dat;
    logic [EXC_W-1:0]  exc;
    logic              ds;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  entry_t h_q, s_q, h_d, s_d, in_ent;
  logic   flush_pend_q, flush_pend_d;
  logic   in_ready_q, in_ready_d;
  logic   in_fire, out_fire, flush_apply;
  state_t state;

  assign in_ent      = '{vld: 1'b1, dat: in_data, exc: in_exc, ds: in_ds};
  assign state       = state_t'({s_q.vld, h_q.vld});
  assign in_fire     = in_valid & in_ready_q;
  assign out_fire    = h_q.vld & out_ready & ~hold;
  // A flush seen while held is remembered and applied on the first unheld edge.
  assign flush_apply = (flush | flush_pend_q) & ~hold;

  always_comb begin
    h_d          = h_q;
    s_d          = s_q;
    flush_pend_d = flush_pend_q;
    if (hold) begin
      if (flush) flush_pend_d = 1'b1;
    end else begin
      flush_pend_d = 1'b0;
    end
    if (flush_apply) begin
      h_d = '0;
      s_d = '0;
    end else begin
      case (state)
        EMPTY: if (in_fire) h_d = in_ent;
        ONE: begin
          if (in_fire && out_fire)  h_d = in_ent;
          else if (in_fire)         s_d = in_ent;
          else if (out_fire)        h_d = '0;
        end
        FULL: begin
          if (out_fire) begin
            h_d = s_q;
            s_d = '0;
          end
        end
        default: begin
          h_d = '0;
          s_d = '0;
        end
      endcase
    end
    in_ready_d = ~s_d.vld & ~flush_pend_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_q          <= '0;
      s_q          <= '0;
      flush_pend_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      h_q          <= h_d;
      s_q          <= s_d;
      flush_pend_q <= flush_pend_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = h_q.vld;
  assign out_data  = h_q.dat;
  assign out_exc   = h_q.exc;
  assign out_ds    = h_q.ds;
  assign occupancy = {1'b0, h_q.vld} + {1'b0, s_q.vld};

`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [CNT_W:0] flush_sum;
  assign flush_sum = {1'b0, flush_cnt} + (CNT_W+1)'(occupancy);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (h_q.vld && !out_fire && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_apply)
        flush_cnt <= flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: a queue-based reference model fed by the driver, checked by a negedge monitor.
module tb_pipe_stage_buf;
  localparam int DATA_W = 192;
  localparam int EXC_W  = 9;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid, in_ready, in_ds;
  logic [DATA_W-1:0] in_data;
  logic [EXC_W-1:0]  in_exc;
  logic              out_valid, out_ready, out_ds;
  logic [DATA_W-1:0] out_data;
  logic [EXC_W-1:0]  out_exc;
  logic              hold, flush;
  logic [1:0]        occupancy;
`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [15:0]       stall_cnt, flush_cnt;
`endif

  always #5 clock = ~clock;

  pipe_stage_buf dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_exc(in_exc), .in_ds(in_ds),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_exc(out_exc), .out_ds(out_ds),
    .hold(hold), .flush(flush), .occupancy(occupancy)
`ifdef PIPE_STAGE_BUF_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [EXC_W-1:0]  e;
    logic              ds;
  } ent_t;

  // Reference model: an in-order queue of at most two entries plus a pending-flush flag.
  ent_t exp_q[$];
  logic m_rdy  = 1'b0;
  logic m_pend = 1'b0;
  int   occ_pre = 0;
  int   m_stall = 0;
  int   m_flush = 0;
  bit   mon_en  = 1'b0;
  logic p_iv = 1'b0, p_h = 1'b0, p_f = 1'b0, p_rdy = 1'b0;
  ent_t p_ent;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(int unsigned v);
    ent_t e;
    e.d  = DATA_W'(v);
    e.e  = EXC_W'(v) | EXC_W'(1);
    e.ds = v[0];
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e;
    e.d  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    e.e  = EXC_W'($urandom);
    e.ds = 1'($urandom);
    return e;
  endfunction

  // Apply what the previous cycle's inputs did at the edge just passed (output pops are done by the monitor).
  task automatic apply_prev();
    if ((p_f || m_pend) && !p_h) begin
      m_flush = (m_flush + occ_pre > 65535) ? 65535 : m_flush + occ_pre;
      exp_q.delete();
      m_pend = 1'b0;
    end else begin
      if (p_f && p_h) m_pend = 1'b1;
      if (p_iv && p_rdy) exp_q.push_back(p_ent);
    end
    m_rdy = (exp_q.size() < 2) && !m_pend;
  endtask

  task automatic step(logic iv, ent_t e, logic ordy, logic h, logic f);
    @(posedge clock);
    #2;
    apply_prev();
    in_valid = iv; in_data = e.d; in_exc = e.e; in_ds = e.ds;
    out_ready = ordy; hold = h; flush = f;
    p_iv = iv; p_ent = e; p_h = h; p_f = f; p_rdy = m_rdy;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_data = '0; in_exc = '0; in_ds = 1'b0;
    out_ready = 1'b0; hold = 1'b0; flush = 1'b0;
    p_iv = 1'b0; p_h = 1'b0; p_f = 1'b0; p_rdy = 1'b0;
  endtask

  // Asserts reset between edges; outputs must clear before any clock edge.
  task automatic do_reset();
    mon_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_exc", out_exc, 0);
    chk("rst_out_ds", out_ds, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_in_ready", in_ready, 0);
    idle_inputs();
    exp_q.delete();
    m_pend = 1'b0; m_rdy = 1'b0; occ_pre = 0; m_stall = 0; m_flush = 0;
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clock);
      if (mon_en) begin
        occ_pre = exp_q.size();
        chk("out_valid", out_valid, occ_pre != 0);
        chk("occupancy", occupancy, occ_pre);
        chk("in_ready", in_ready, m_rdy);
`ifdef PIPE_STAGE_BUF_PERF_EN
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
        if (occ_pre != 0 && !(out_ready && !hold) && m_stall != 65535) m_stall++;
`endif
        if (occ_pre != 0) begin
          chk("out_data", out_data, exp_q[0].d);
          chk("out_exc", out_exc, exp_q[0].e);
          chk("out_ds", out_ds, exp_q[0].ds);
          if (out_ready && !hold) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin : driver
    reset = 1'b1;
    idle_inputs();
    do_reset();

    // Streaming 1..4 at full rate.
    for (int i = 1; i <= 4; i++) step(1'b1, mk(i), 1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, mk(0), 1'b1, 1'b0, 1'b0);

    // Backpressure to FULL, then drain.
    step(1'b1, mk(32'hAA), 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(32'hBB), 1'b0, 1'b0, 1'b0);
    step(1'b0, mk(0), 1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b0, mk(0), 1'b1, 1'b0, 1'b0);

    // Flush while FULL; the concurrent 0xCC offer must be dropped.
    step(1'b1, mk(32'h11), 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(32'h22), 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(32'hCC), 1'b0, 1'b0, 1'b1);
    step(1'b0, mk(0), 1'b1, 1'b0, 1'b0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_exc", out_exc, 0);
    chk("flush_out_data", out_data, 0);
    repeat (2) step(1'b0, mk(0), 1'b1, 1'b0, 1'b0);

    // Deferred flush under hold with one entry held.
    step(1'b1, mk(32'h33), 1'b0, 1'b0, 1'b0);
    step(1'b0, mk(0), 1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b1, mk(32'h44), 1'b1, 1'b1, 1'b0);
    step(1'b0, mk(0), 1'b0, 1'b0, 1'b0);
    step(1'b0, mk(0), 1'b0, 1'b0, 1'b0);
    chk("dflush_out_valid", out_valid, 0);
    repeat (2) step(1'b0, mk(0), 1'b1, 1'b0, 1'b0);

    // Reset mid-cycle while FULL with a flush pending.
    step(1'b1, mk(32'h55), 1'b0, 1'b0, 1'b0);
    step(1'b1, mk(32'h66), 1'b0, 1'b0, 1'b0);
    step(1'b0, mk(0), 1'b0, 1'b1, 1'b1);
    step(1'b0, mk(0), 1'b0, 1'b1, 1'b0);
    do_reset();
    repeat (2) step(1'b0, mk(0), 1'b0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++)
      step(($urandom % 4) != 0, rnd_ent(), ($urandom % 3) != 0, ($urandom % 5) == 0, ($urandom % 23) == 0);
    repeat (3) step(1'b0, mk(0), 1'b1, 1'b0, 1'b0);

`ifdef PIPE_STAGE_BUF_PERF_EN
    do_reset();
    step(1'b1, mk(32'h77), 1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b0, mk(0), 1'b1, 1'b1, 1'b0);
    step(1'b1, mk(32'h88), 1'b0, 1'b1, 1'b0);
    chk("stall_cnt_5", stall_cnt, 5);
    step(1'b0, mk(0), 1'b0, 1'b0, 1'b1);
    step(1'b0, mk(0), 1'b0, 1'b0, 1'b0);
    chk("flush_cnt_2", flush_cnt, 2);
    step(1'b1, mk(32'h99), 1'b0, 1'b0, 1'b0);
    repeat (65540) step(1'b0, mk(0), 1'b0, 1'b1, 1'b0);
    chk("stall_cnt_sat", stall_cnt, 16'hFFFF);
`endif

    @(posedge clock);
    #2 mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
